booth_div_8x4: RTL and testbench

- Sequential restoring divider: the inverse of the 4x4 Booth multiplier datapath. Given the 2N-bit product P and the N-bit operand B, it recovers A = P / B and the remainder.
- Produces one quotient bit per clock, MSB first.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic block. It is used for round-trip checks of multiplier results and for general 8/4 division.

---
 rtl/booth_div_8x4.sv | 207 ++++++++++++++++++++
 tb/tb_booth_div_8x4.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_div_8x4.sv
// booth_div_8x4: sequential restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock, MSB first.
// Latency: done is high in the cycle after edge E+N+1 for a normal divide and after edge E+2 for an error (E = accepting edge).
// Backpressure: start is taken only while busy=0 (IDLE or the DONE cycle); start while busy is ignored and operands stay latched.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   start               - request pulse, accepted only when busy=0
//   dividend, divisor   - operands, captured on the accepting edge
//   busy, done          - in-progress flag and single-cycle result-valid pulse
//   quotient, remainder - result, held from one DONE entry to the next
//   div_by_zero         - result flag: divisor was zero
//   overflow            - result flag: quotient would not fit in N bits
//
// The design assumes N >= 2.

module booth_div_8x4 #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // S_LOAD sits between the accepting edge and the range check, so the
    // zero/overflow compare works on registered operands rather than on the
    // input pins. It adds one cycle to both the normal and the error path.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_ERR,
        S_DONE
    } state_t;

    state_t          state_q, state_d;

    // Latched operands. rem_q is loaded with the upper dividend half on
    // acceptance and becomes the (N+1)-bit partial remainder during CALC.
    // lo_q holds the lower dividend half and is shifted left one bit per
    // CALC step so its MSB is always the next dividend bit to bring down.
    logic [N:0]      rem_q, rem_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_dz_q, err_dz_d;

    // Result registers, written only on entry to DONE.
    logic [N-1:0]    quotient_q, quotient_d;
    logic [N-1:0]    remainder_q, remainder_d;
    logic            div_by_zero_q, div_by_zero_d;
    logic            overflow_q, overflow_d;

    // Datapath for a single restoring step.
    logic [N:0]      r_shift;
    logic [N:0]      r_diff;
    logic            q_bit;
    logic [N-1:0]    acc_next;
    logic            accept;

    always_comb begin
        r_shift  = {rem_q[N-1:0], lo_q[N-1]};
        r_diff   = r_shift - {1'b0, dvs_q};
        // The compare is N+1 bits wide, so the bit shifted out of the
        // N-bit remainder is never lost.
        q_bit    = (r_shift >= {1'b0, dvs_q});
        acc_next = {acc_q[N-2:0], q_bit};
    end

    // busy is low in IDLE and DONE, so a start in the DONE cycle relaunches.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        lo_d          = lo_q;
        dvs_d         = dvs_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        err_dz_d      = err_dz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_d   = {1'b0, dividend[2*N-1:N]};
                    lo_d    = dividend[N-1:0];
                    dvs_d   = divisor;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                busy = 1'b1;
                if (dvs_q == '0) begin
                    err_dz_d = 1'b1;
                    state_d  = S_ERR;
                end else if (rem_q[N-1:0] >= dvs_q) begin
                    // Upper half already >= divisor: quotient needs > N bits.
                    err_dz_d = 1'b0;
                    state_d  = S_ERR;
                end else begin
                    cnt_d   = CW'(N - 1);
                    acc_d   = '0;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                busy  = 1'b1;
                rem_d = q_bit ? r_diff : r_shift;
                lo_d  = lo_q << 1;
                acc_d = acc_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quotient_d    = acc_next;
                    remainder_d   = q_bit ? r_diff[N-1:0] : r_shift[N-1:0];
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                    state_d       = S_DONE;
                end
            end

            S_ERR: begin
                busy       = 1'b1;
                quotient_d = '1;
                if (err_dz_q) begin
                    // lo_q is untouched on the error path, so it still holds
                    // the lower dividend half.
                    remainder_d   = lo_q;
                    div_by_zero_d = 1'b1;
                    overflow_d    = 1'b0;
                end else begin
                    remainder_d   = '0;
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b1;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                done = 1'b1;
                if (accept) begin
                    rem_d   = {1'b0, dividend[2*N-1:N]};
                    lo_d    = dividend[N-1:0];
                    dvs_d   = divisor;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            lo_q          <= '0;
            dvs_q         <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            err_dz_q      <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            lo_q          <= lo_d;
            dvs_q         <= dvs_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            err_dz_q      <= err_dz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_booth_div_8x4.sv
// tb_booth_div_8x4: directed and exhaustive checks of booth_div_8x4.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).

module tb_booth_div_8x4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int passed;
    int total;
    int done_cnt;

    booth_div_8x4 #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) done_cnt++;
    end

    // Drive one request from a negedge and wait for done. lat counts the
    // negedges after the start cycle, so the first cycle after start is 1.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [3:0] q, output logic [3:0] r,
                           output logic dz, output logic ov, output int lat);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        ov = overflow;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 4'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 12'h000)
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, done, quotient, remainder, div_by_zero, overflow});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_roundtrip();
        logic [7:0] a_t [4] = '{8'd143, 8'd15, 8'd225, 8'd1};
        logic [3:0] b_t [4] = '{4'd13, 4'd5, 4'd15, 4'd1};
        logic [3:0] q_t [4] = '{4'd11, 4'd3, 4'd15, 4'd1};
        logic [3:0] q, r;
        logic dz, ov;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_div(a_t[i], b_t[i], q, r, dz, ov, lat);
            total++;
            if (q !== q_t[i] || r !== 4'd0 || dz !== 1'b0 || ov !== 1'b0)
                $display("FAIL roundtrip %0d/%0d: got q=%0d r=%0d dz=%b ov=%b expected q=%0d r=0 flags 0",
                         a_t[i], b_t[i], q, r, dz, ov, q_t[i]);
            else passed++;
            total++;
            if (lat !== 6)
                $display("FAIL roundtrip_latency %0d/%0d: got %0d expected 6", a_t[i], b_t[i], lat);
            else passed++;
        end
    endtask

    task automatic test_remainder();
        logic [3:0] q, r;
        logic dz, ov;
        int lat;
        run_div(8'd200, 4'd15, q, r, dz, ov, lat);
        total++;
        if (q !== 4'd13 || r !== 4'd5 || dz !== 1'b0 || ov !== 1'b0)
            $display("FAIL rem_200_15: got q=%0d r=%0d dz=%b ov=%b expected q=13 r=5", q, r, dz, ov);
        else passed++;
        run_div(8'd7, 4'd4, q, r, dz, ov, lat);
        total++;
        if (q !== 4'd1 || r !== 4'd3 || dz !== 1'b0 || ov !== 1'b0)
            $display("FAIL rem_7_4: got q=%0d r=%0d dz=%b ov=%b expected q=1 r=3", q, r, dz, ov);
        else passed++;
    endtask

    task automatic test_errors();
        logic [3:0] q, r;
        logic dz, ov;
        int lat;
        run_div(8'd143, 4'd0, q, r, dz, ov, lat);
        total++;
        if (q !== 4'hF || r !== 4'hF || dz !== 1'b1 || ov !== 1'b0)
            $display("FAIL div0: got q=%h r=%h dz=%b ov=%b expected q=f r=f dz=1 ov=0", q, r, dz, ov);
        else passed++;
        total++;
        if (lat !== 3)
            $display("FAIL div0_latency: got %0d expected 3", lat);
        else passed++;
        run_div(8'hF0, 4'h5, q, r, dz, ov, lat);
        total++;
        if (q !== 4'hF || r !== 4'h0 || dz !== 1'b0 || ov !== 1'b1 || lat !== 3)
            $display("FAIL ovf_f0_5: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=f r=0 dz=0 ov=1 lat=3",
                     q, r, dz, ov, lat);
        else passed++;
        run_div(8'h50, 4'h5, q, r, dz, ov, lat);
        total++;
        if (q !== 4'hF || r !== 4'h0 || dz !== 1'b0 || ov !== 1'b1)
            $display("FAIL ovf_50_5: got q=%h r=%h dz=%b ov=%b expected q=f r=0 dz=0 ov=1", q, r, dz, ov);
        else passed++;
    endtask

    task automatic test_ignore_start();
        int lat;
        int d0;
        @(negedge clk);
        d0       = done_cnt;
        start    = 1'b1;
        dividend = 8'd143;
        divisor  = 4'd13;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // Second request while busy, with different operands left applied.
        total++;
        if (busy !== 1'b1)
            $display("FAIL ignore_busy: got busy=%b expected 1", busy);
        else passed++;
        start    = 1'b1;
        dividend = 8'd15;
        divisor  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        lat   = 3;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (quotient !== 4'd11 || remainder !== 4'd0 || lat !== 6)
            $display("FAIL ignore_result: got q=%0d r=%0d lat=%0d expected q=11 r=0 lat=6",
                     quotient, remainder, lat);
        else passed++;
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt - d0 !== 1)
            $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] q, r;
        logic dz, ov;
        int lat;
        int d0;
        d0 = done_cnt;
        run_div(8'd225, 4'd15, q, r, dz, ov, lat);
        total++;
        if (q !== 4'd15 || r !== 4'd0)
            $display("FAIL b2b_first: got q=%0d r=%0d expected q=15 r=0", q, r);
        else passed++;
        // Issued in the done cycle of the previous request.
        run_div(8'd200, 4'd15, q, r, dz, ov, lat);
        total++;
        if (q !== 4'd13 || r !== 4'd5 || lat !== 6)
            $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d expected q=13 r=5 lat=6", q, r, lat);
        else passed++;
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt - d0 !== 2)
            $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_reset_abort();
        logic [3:0] q, r;
        logic dz, ov;
        int lat;
        int d0;
        d0       = done_cnt;
        start    = 1'b1;
        dividend = 8'd225;
        divisor  = 4'd15;
        @(negedge clk);
        start = 1'b0;
        // Cycles after start: 1 load, 2..5 CALC; cycle 4 is the 3rd CALC cycle.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 12'h000)
            $display("FAIL abort_outputs: got %b expected all zero",
                     {busy, done, quotient, remainder, div_by_zero, overflow});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt - d0 !== 0 || busy !== 1'b0)
            $display("FAIL abort_no_done: got %0d pulses busy=%b expected 0 pulses busy=0",
                     done_cnt - d0, busy);
        else passed++;
        run_div(8'd225, 4'd15, q, r, dz, ov, lat);
        total++;
        if (q !== 4'd15 || r !== 4'd0 || dz !== 1'b0 || ov !== 1'b0 || lat !== 6)
            $display("FAIL abort_recover: got q=%0d r=%0d dz=%b ov=%b lat=%0d expected 15 r0 lat=6",
                     q, r, dz, ov, lat);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [3:0] q, r, eq, er;
        logic dz, ov, edz, eov;
        int lat, elat;
        int d0;
        int bad;
        @(negedge clk);
        d0  = done_cnt;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 4'hF; er = 4'(a % 16); edz = 1'b1; eov = 1'b0; elat = 3;
                end else if ((a / 16) >= b) begin
                    eq = 4'hF; er = 4'h0; edz = 1'b0; eov = 1'b1; elat = 3;
                end else begin
                    eq = 4'(a / b); er = 4'(a % b); edz = 1'b0; eov = 1'b0; elat = 6;
                end
                run_div(8'(a), 4'(b), q, r, dz, ov, lat);
                total++;
                if (q !== eq || r !== er || dz !== edz || ov !== eov || lat !== elat) begin
                    bad++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%b ov=%b lat=%0d expected q=%0d r=%0d dz=%b ov=%b lat=%0d",
                             a, b, q, r, dz, ov, lat, eq, er, edz, eov, elat);
                end else passed++;
                if (bad > 20) break;
            end
            if (bad > 20) break;
        end
        repeat (5) @(negedge clk);
        total++;
        if (done_cnt - d0 !== 4096)
            $display("FAIL sweep_done_count: got %0d expected 4096", done_cnt - d0);
        else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 4'h0;
        test_reset();
        test_roundtrip();
        test_remainder();
        test_errors();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
